// File: rtl/conv_viterbi_codec.sv
// Rate-1/2, K=3 convolutional encoder (g1=111, g0=101) and an independent
// hard-decision Viterbi decoder with register-exchange survivors.
module conv_viterbi_codec #(
    parameter int TB_DEPTH = 16,
    parameter int PM_W     = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enc_enable_i,
    input  logic       enc_d_i,
    output logic       enc_valid_o,
    output logic [1:0] enc_d_o,
    input  logic       dec_enable_i,
    input  logic [1:0] dec_d_i,
    output logic       dec_valid_o,
    output logic       dec_d_o
);

    localparam int               CNT_W     = $clog2(TB_DEPTH + 2);
    localparam logic [CNT_W-1:0] FILL_DONE = CNT_W'(TB_DEPTH + 1);

    // Branch output when entering state {d,a} from predecessor {a,b}.
    function automatic logic [1:0] branch_out(input logic d, input logic a, input logic b);
        return {d ^ a ^ b, d ^ b};
    endfunction

    function automatic logic [1:0] hamming(input logic [1:0] x, input logic [1:0] y);
        logic [1:0] diff;
        diff = x ^ y;
        return {1'b0, diff[1]} + {1'b0, diff[0]};
    endfunction

    // ------------------------------------------------------------------ encoder
    logic [1:0] enc_s_q,     enc_s_d;
    logic [1:0] enc_sym_q,   enc_sym_d;
    logic       enc_valid_q, enc_valid_d;

    // Encoder next state: shift the new bit into {s1,s0} and form {c1,c0}.
    always_comb begin
        // NOTE: every next-state variable gets a default first, so no path leaves it unassigned and no latch is inferred.
        enc_s_d     = enc_s_q;
        enc_sym_d   = enc_sym_q;
        enc_valid_d = enc_enable_i;
        if (enc_enable_i) begin
            enc_sym_d = branch_out(enc_d_i, enc_s_q[1], enc_s_q[0]);
            enc_s_d   = {enc_d_i, enc_s_q[1]};
        end
    end

    // Encoder registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            enc_s_q     <= 2'b00;
            enc_sym_q   <= 2'b00;
            enc_valid_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of statement order.
            enc_s_q     <= enc_s_d;
            enc_sym_q   <= enc_sym_d;
            enc_valid_q <= enc_valid_d;
        end
    end

    assign enc_valid_o = enc_valid_q;
    assign enc_d_o     = enc_sym_q;

    // ------------------------------------------------------------------ decoder
    logic [PM_W-1:0]     pm_q [4];
    logic [PM_W-1:0]     pm_d [4];
    logic [TB_DEPTH-1:0] sv_q [4];
    logic [TB_DEPTH-1:0] sv_d [4];
    logic [CNT_W-1:0]    fill_q, fill_d;
    logic                dec_bit_q, dec_bit_d;

    logic [PM_W-1:0] cand0    [4];
    logic [PM_W-1:0] cand1    [4];
    logic [PM_W-1:0] cand_min [4];
    logic            pick1    [4];
    logic [PM_W-1:0] norm_min;
    logic [PM_W-1:0] best_pm;
    logic [1:0]      best;

    // Add-compare-select per next state {d,a}; ties keep predecessor {a,0}.
    always_comb begin
        for (int s = 0; s < 4; s++) begin
            cand0[s]    = pm_q[{s[0], 1'b0}] + PM_W'(hamming(dec_d_i, branch_out(s[1], s[0], 1'b0)));
            cand1[s]    = pm_q[{s[0], 1'b1}] + PM_W'(hamming(dec_d_i, branch_out(s[1], s[0], 1'b1)));
            pick1[s]    = cand1[s] < cand0[s];
            cand_min[s] = pick1[s] ? cand1[s] : cand0[s];
        end
    end

    // Smallest new candidate (for normalization) and best current state (lowest index on ties).
    always_comb begin
        norm_min = cand_min[0];
        best_pm  = pm_q[0];
        best     = 2'd0;
        for (int s = 1; s < 4; s++) begin
            if (cand_min[s] < norm_min) norm_min = cand_min[s];
            if (pm_q[s] < best_pm) begin
                best_pm = pm_q[s];
                best    = 2'(s);
            end
        end
    end

    // Decoder next state: normalized metrics, survivor exchange, output and fill count.
    always_comb begin
        for (int s = 0; s < 4; s++) begin
            pm_d[s] = pm_q[s];
            sv_d[s] = sv_q[s];
        end
        fill_d    = fill_q;
        dec_bit_d = dec_bit_q;
        if (dec_enable_i) begin
            for (int s = 0; s < 4; s++) begin
                pm_d[s] = cand_min[s] - norm_min;
                sv_d[s] = {sv_q[{s[0], pick1[s]}][TB_DEPTH-2:0], s[1]};
            end
            dec_bit_d = sv_q[best][TB_DEPTH-1];
            if (fill_q != FILL_DONE) fill_d = fill_q + CNT_W'(1);
        end
    end

    // Decoder registers; start as if the encoder is in state 0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: survivors are plain flops, not RAM, and are cleared so a mid-stream reset restarts decoding from a clean trellis.
            for (int s = 0; s < 4; s++) begin
                pm_q[s] <= (s == 0) ? '0 : PM_W'(4);
                sv_q[s] <= '0;
            end
            fill_q    <= '0;
            dec_bit_q <= 1'b0;
        end else begin
            for (int s = 0; s < 4; s++) begin
                pm_q[s] <= pm_d[s];
                sv_q[s] <= sv_d[s];
            end
            fill_q    <= fill_d;
            dec_bit_q <= dec_bit_d;
        end
    end

    assign dec_valid_o = (fill_q == FILL_DONE);
    assign dec_d_o     = dec_bit_q;

endmodule

// File: tb/tb_conv_viterbi_codec.sv
// Self-checking bench for conv_viterbi_codec: behavioural encoder/Viterbi model
// with full-length path histories, loopback stimulus and channel error patterns.
module tb_conv_viterbi_codec;

    localparam int D = 16;

    typedef enum int {M_CLEAN, M_SINGLE, M_BURST, M_ZERO, M_NOISE} mode_e;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       enc_enable_i = 1'b0;
    logic       enc_d_i = 1'b0;
    logic       enc_valid_o;
    logic [1:0] enc_d_o;
    logic       dec_enable_i = 1'b0;
    logic [1:0] dec_d_i = 2'b00;
    logic       dec_valid_o;
    logic       dec_d_o;

    always #5 clk = ~clk;

    conv_viterbi_codec #(.TB_DEPTH(D), .PM_W(6)) dut (
        .clk          (clk),
        .rst          (rst),
        .enc_enable_i (enc_enable_i),
        .enc_d_i      (enc_d_i),
        .enc_valid_o  (enc_valid_o),
        .enc_d_o      (enc_d_o),
        .dec_enable_i (dec_enable_i),
        .dec_d_i      (dec_d_i),
        .dec_valid_o  (dec_valid_o),
        .dec_d_o      (dec_d_o)
    );

    int checks = 0;
    int errors = 0;

    // Model state
    bit         enc_hist[$];
    logic [1:0] exp_enc_d;
    logic       exp_enc_valid;
    int         pm[4];
    bit [511:0] surv[4];
    int         nsym;
    logic       exp_dec_d;
    logic       exp_dec_valid;
    bit         truth[$];
    bit         src[512];
    bit         dec_log[$];
    bit         ref_log[$];

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic model_reset();
        enc_hist.delete();
        truth.delete();
        exp_enc_d     = 2'b00;
        exp_enc_valid = 1'b0;
        pm[0] = 0; pm[1] = 4; pm[2] = 4; pm[3] = 4;
        for (int s = 0; s < 4; s++) surv[s] = '0;
        nsym          = 0;
        exp_dec_d     = 1'b0;
        exp_dec_valid = 1'b0;
    endtask

    // Encoder as a convolution over the input history.
    task automatic model_enc(input bit en, input bit u);
        int n;
        bit u1, u2;
        if (en) begin
            enc_hist.push_back(u);
            n  = enc_hist.size();
            u1 = (n >= 2) ? enc_hist[n-2] : 1'b0;
            u2 = (n >= 3) ? enc_hist[n-3] : 1'b0;
            exp_enc_d     = {u ^ u1 ^ u2, u ^ u2};
            exp_enc_valid = 1'b1;
        end else begin
            exp_enc_valid = 1'b0;
        end
    endtask

    // Viterbi with unbounded metrics and complete per-state path histories.
    task automatic model_dec(input logic [1:0] r);
        int         best;
        int         npm[4];
        bit [511:0] npath[4];
        int         c[2];
        int         d, a, bw;
        best = 0;
        for (int s = 1; s < 4; s++) if (pm[s] < pm[best]) best = s;
        exp_dec_d = (nsym >= D) ? surv[best][nsym-D] : 1'b0;
        for (int ns = 0; ns < 4; ns++) begin
            d = ns / 2;
            a = ns % 2;
            for (int b = 0; b < 2; b++) begin
                c[b] = pm[a*2+b] + ((int'(r[1]) != (d ^ a ^ b)) ? 1 : 0)
                                 + ((int'(r[0]) != (d ^ b)) ? 1 : 0);
            end
            bw = (c[0] <= c[1]) ? 0 : 1;
            npm[ns]         = c[bw];
            npath[ns]       = surv[a*2+bw];
            npath[ns][nsym] = d[0];
        end
        pm   = npm;
        surv = npath;
        nsym++;
        exp_dec_valid = (nsym >= D + 1);
    endtask

    task automatic compare_outputs();
        check("enc_valid", enc_valid_o, exp_enc_valid);
        check("enc_sym",   enc_d_o,     exp_enc_d);
        check("dec_valid", dec_valid_o, exp_dec_valid);
        check("dec_bit",   dec_d_o,     exp_dec_d);
    endtask

    // Drive one cycle (called #1 after a rising edge), update models, compare.
    task automatic step(input bit e_en, input bit u, input bit d_en, input logic [1:0] sym);
        enc_enable_i = e_en;
        enc_d_i      = u;
        dec_enable_i = d_en;
        dec_d_i      = sym;
        @(posedge clk);
        #1;
        model_enc(e_en, u);
        if (d_en) model_dec(sym);
        compare_outputs();
    endtask

    task automatic apply_reset();
        rst          = 1'b0;
        enc_enable_i = 1'b0;
        enc_d_i      = 1'b0;
        dec_enable_i = 1'b0;
        dec_d_i      = 2'b00;
        #1;
        check("rst_enc_valid", enc_valid_o, 0);
        check("rst_enc_sym",   enc_d_o,     0);
        check("rst_dec_valid", dec_valid_o, 0);
        check("rst_dec_bit",   dec_d_o,     0);
        model_reset();
        #2 rst = 1'b1;
        @(posedge clk);
        #1;
        compare_outputs();
    endtask

    // Encoder -> 1-cycle channel register (with optional flips) -> decoder.
    task automatic run_link(input int nbits, input mode_e mode, input bit gaps,
                            input int stall_at, input bit chk_truth, input bit log_en);
        bit         have_sym, stalling, e_en, u, d_en;
        logic [1:0] pend, sym;
        int         sent, cyc, bit_errs, k, fb;
        have_sym = 1'b0; pend = 2'b00; sent = 0; cyc = 0; bit_errs = 0;
        if (log_en) dec_log.delete();
        while ((sent < nbits || have_sym) && cyc < 4000) begin
            stalling = (stall_at >= 0) && (cyc >= stall_at) && (cyc < stall_at + 3);
            e_en = (sent < nbits) && !stalling && (!gaps || $urandom_range(0, 3) != 0);
            u    = (mode == M_ZERO) ? 1'b0 : src[sent];
            d_en = have_sym && !stalling;
            sym  = pend;
            k    = nsym;
            case (mode)
                M_SINGLE: if (k % 8 == 3) begin
                    fb = int'($urandom_range(0, 1));
                    sym[fb] = ~sym[fb];
                end
                M_BURST:  if (k % 8 == 1 || k % 8 == 2) sym[1] = ~sym[1];
                M_NOISE:  for (int b = 0; b < 2; b++) if ($urandom_range(0, 7) == 0) sym[b] = ~sym[b];
                default: ;
            endcase
            if (e_en) begin
                truth.push_back(u);
                sent++;
            end
            step(e_en, u, d_en, sym);
            if (d_en && exp_dec_valid) begin
                if (log_en) dec_log.push_back(dec_d_o);
                if (chk_truth) begin
                    check("decoded_vs_source", dec_d_o, truth[nsym-1-D]);
                    if (dec_d_o !== truth[nsym-1-D]) bit_errs++;
                end
                if (mode == M_ZERO) check("zero_stream_out", dec_d_o, 0);
            end
            if (d_en && nsym == D)     check("valid_before_fill", dec_valid_o, 0);
            if (d_en && nsym == D + 1) check("valid_after_fill",  dec_valid_o, 1);
            if (d_en) have_sym = 1'b0;
            if (enc_valid_o) begin
                pend     = enc_d_o;
                have_sym = 1'b1;
            end
            cyc++;
        end
        check("link_completed", (cyc < 4000) ? 1 : 0, 1);
        if (chk_truth) check("bit_errors", bit_errs, 0);
    endtask

    initial begin
        logic [1:0] vec_out [6];
        bit         vec_in  [6];
        int         mism;
        vec_in  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        vec_out = '{2'b11, 2'b10, 2'b00, 2'b01, 2'b01, 2'b11};
        for (int i = 0; i < 512; i++) src[i] = 1'($urandom_range(0, 1));
        model_reset();
        #6;

        // 1: encoder reference vectors
        apply_reset();
        for (int i = 0; i < 6; i++) begin
            step(1'b1, vec_in[i], 1'b0, 2'b00);
            check("enc_vector", enc_d_o, vec_out[i]);
            check("enc_vector_valid", enc_valid_o, 1);
        end
        step(1'b0, 1'b0, 1'b0, 2'b00);
        check("enc_idle_valid", enc_valid_o, 0);
        check("enc_idle_hold", enc_d_o, 2'b11);

        // 2: clean loopback
        apply_reset();
        run_link(256, M_CLEAN, 1'b0, -1, 1'b1, 1'b1);
        ref_log = dec_log;

        // 3: single flips every 8th symbol
        apply_reset();
        run_link(256, M_SINGLE, 1'b0, -1, 1'b1, 1'b0);

        // 4: two consecutive bad r1 per 8 symbols
        apply_reset();
        run_link(256, M_BURST, 1'b0, -1, 1'b1, 1'b0);

        // 5a: 3-cycle stall gives the same decoded stream
        apply_reset();
        run_link(256, M_CLEAN, 1'b0, 60, 1'b1, 1'b1);
        check("stall_log_len", dec_log.size(), ref_log.size());
        mism = 0;
        for (int i = 0; i < dec_log.size() && i < ref_log.size(); i++)
            if (dec_log[i] != ref_log[i]) mism++;
        check("stall_log_bits", mism, 0);

        // 5b: reset mid-stream, then decoding restarts from state 0
        apply_reset();
        run_link(40, M_CLEAN, 1'b0, -1, 1'b1, 1'b0);
        check("valid_before_midreset", dec_valid_o, 1);
        apply_reset();
        check("valid_after_midreset", dec_valid_o, 0);
        run_link(60, M_CLEAN, 1'b0, -1, 1'b1, 1'b0);

        // 6: all-zero input
        apply_reset();
        run_link(100, M_ZERO, 1'b0, -1, 1'b1, 1'b0);

        // Random channel noise with encoder gaps, checked against the model
        apply_reset();
        run_link(256, M_NOISE, 1'b1, -1, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
